// File: rtl/scaler_bank_pkg.sv
// Shared definitions for the prescaled scaler bank: register map, field positions,
// bus FSM states and the byte-lane merge helper.
package scaler_bank_pkg;

    // Byte offsets of the register map (block decodes adr[11:2])
    localparam logic [11:0] CTRL_OFFSET     = 12'h000;
    localparam logic [11:0] STATUS_OFFSET   = 12'h004;
    localparam logic [11:0] PRESCALE_OFFSET = 12'h400;
    localparam logic [11:0] COUNT_OFFSET    = 12'h800;

    localparam logic [1:0] REGION_MISC     = CTRL_OFFSET[11:10];
    localparam logic [1:0] REGION_PRESCALE = PRESCALE_OFFSET[11:10];
    localparam logic [1:0] REGION_COUNT    = COUNT_OFFSET[11:10];
    localparam logic [7:0] IDX_CTRL        = CTRL_OFFSET[9:2];
    localparam logic [7:0] IDX_STATUS      = STATUS_OFFSET[9:2];

    localparam int CTRL_USE_PPS_BIT = 31;
    localparam int CTRL_PERIOD_MSB  = 30;
    localparam int STATUS_UPD_MSB   = 15;
    localparam int COUNT_SAT_BIT    = 31;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } wb_state_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/scaler_channel.sv
// One scaler channel: prescale counter, saturating accumulator with sticky
// saturation flag, and the per-interval latch that the bus reads back.
module scaler_channel
    import scaler_bank_pkg::*;
#(
    parameter int COUNT_WIDTH   = 16,
    parameter int PRESCALE_BITS = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     evt_i,
    input  logic                     strobe_i,
    input  logic                     clr_i,
    input  logic [PRESCALE_BITS-1:0] prescale_i,
    output logic [COUNT_WIDTH-1:0]   count_o,
    output logic                     sat_o
);

    localparam logic [COUNT_WIDTH-1:0] ACC_MAX = {COUNT_WIDTH{1'b1}};

    logic [PRESCALE_BITS-1:0] psc_q, psc_d;
    logic [COUNT_WIDTH-1:0]   acc_q, acc_d;
    logic                     sat_q, sat_d;
    logic [COUNT_WIDTH-1:0]   lat_q, lat_d;
    logic                     lat_sat_q, lat_sat_d;
    logic                     acc_tick;

    always_comb begin
        psc_d     = psc_q;
        acc_d     = acc_q;
        sat_d     = sat_q;
        lat_d     = lat_q;
        lat_sat_d = lat_sat_q;
        acc_tick  = evt_i && ((prescale_i == '0) || (psc_q >= prescale_i));

        if (strobe_i) begin
            // A coincident event opens the new interval instead of closing the old one
            lat_d     = acc_q;
            lat_sat_d = sat_q;
            sat_d     = 1'b0;
            acc_d     = '0;
            psc_d     = '0;
            if (evt_i) begin
                if (prescale_i == '0) acc_d = COUNT_WIDTH'(1);
                else                  psc_d = PRESCALE_BITS'(1);
            end
        end else if (evt_i) begin
            if (acc_tick) begin
                psc_d = '0;
                if (acc_q == ACC_MAX) sat_d = 1'b1;
                else                  acc_d = acc_q + COUNT_WIDTH'(1);
            end else begin
                psc_d = psc_q + PRESCALE_BITS'(1);
            end
        end

        if (clr_i) begin
            psc_d = '0;
            acc_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            psc_q     <= '0;
            acc_q     <= '0;
            sat_q     <= 1'b0;
            lat_q     <= '0;
            lat_sat_q <= 1'b0;
        end else begin
            psc_q     <= psc_d;
            acc_q     <= acc_d;
            sat_q     <= sat_d;
            lat_q     <= lat_d;
            lat_sat_q <= lat_sat_d;
        end
    end

    assign count_o = lat_q;
    assign sat_o   = lat_sat_q;

endmodule

// File: rtl/prescaled_scaler_bank.sv
// Bank of prescaled event scalers latched on a timer or PPS strobe, with a
// WISHBONE classic slave for control and readback.
module prescaled_scaler_bank
    import scaler_bank_pkg::*;
#(
    parameter int NUM_SCALERS   = 32,
    parameter int COUNT_WIDTH   = 16,
    parameter int PRESCALE_BITS = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   pps_i,
    input  logic [NUM_SCALERS-1:0] scal_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [15:0]            wb_adr_i,
    input  logic [31:0]            wb_dat_i,
    input  logic [3:0]             wb_sel_i,
    output logic [31:0]            wb_dat_o,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic                   wb_rty_o
);

    wb_state_e state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [NUM_SCALERS-1:0][PRESCALE_BITS-1:0] prescale_q, prescale_d;
    logic        pps_q, pps_d;
    logic [CTRL_PERIOD_MSB:0] timer_q, timer_d;
    logic [STATUS_UPD_MSB:0]  upd_q, upd_d;

    logic [NUM_SCALERS-1:0][COUNT_WIDTH-1:0] cnt_lat;
    logic [NUM_SCALERS-1:0] sat_lat;
    logic [NUM_SCALERS-1:0] psc_clr;

    logic [1:0]  region;
    logic [7:0]  idx;
    logic        access_fire, wr_fire, ctrl_wr;
    logic [31:0] rdata;
    logic        use_pps, timer_hit, pps_rise, strobe;
    logic [CTRL_PERIOD_MSB:0] period;
    logic        unused_adr_bits;

    assign region          = wb_adr_i[11:10];
    assign idx             = wb_adr_i[9:2];
    assign unused_adr_bits = ^{wb_adr_i[15:12], wb_adr_i[1:0]};

    assign access_fire = (state_q == ST_IDLE) && wb_cyc_i && wb_stb_i;
    assign wr_fire     = access_fire && wb_we_i;
    assign ctrl_wr     = wr_fire && (region == REGION_MISC) && (idx == IDX_CTRL);

    assign use_pps   = ctrl_q[CTRL_USE_PPS_BIT];
    assign period    = ctrl_q[CTRL_PERIOD_MSB:0];
    assign timer_hit = (period != '0) && (timer_q >= period);
    assign pps_rise  = pps_i && !pps_q;
    assign strobe    = use_pps ? pps_rise : timer_hit;

    // Timer restarts at 1 after a hit so consecutive strobes are exactly `period` apart
    always_comb begin
        pps_d = pps_i;
        if (ctrl_wr || (period == '0)) timer_d = '0;
        else if (timer_hit)            timer_d = (CTRL_PERIOD_MSB+1)'(1);
        else                           timer_d = timer_q + (CTRL_PERIOD_MSB+1)'(1);
        upd_d = strobe ? upd_q + (STATUS_UPD_MSB+1)'(1) : upd_q;
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        psc_clr    = '0;
        if (ctrl_wr) ctrl_d = merge_bytes(ctrl_q, wb_dat_i, wb_sel_i);
        if (wr_fire && (region == REGION_PRESCALE)) begin
            for (int i = 0; i < NUM_SCALERS; i++) begin
                if (idx == 8'(i)) begin
                    prescale_d[i] = PRESCALE_BITS'(merge_bytes(32'(prescale_q[i]),
                                                               wb_dat_i, wb_sel_i));
                    psc_clr[i]    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (region)
            REGION_MISC: begin
                if (idx == IDX_CTRL)        rdata = ctrl_q;
                else if (idx == IDX_STATUS) rdata[STATUS_UPD_MSB:0] = upd_q;
            end
            REGION_PRESCALE: begin
                for (int i = 0; i < NUM_SCALERS; i++) begin
                    if (idx == 8'(i)) rdata[PRESCALE_BITS-1:0] = prescale_q[i];
                end
            end
            REGION_COUNT: begin
                for (int i = 0; i < NUM_SCALERS; i++) begin
                    if (idx == 8'(i)) begin
                        rdata[COUNT_WIDTH-1:0] = cnt_lat[i];
                        rdata[COUNT_SAT_BIT]   = sat_lat[i];
                    end
                end
            end
            default: rdata = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        dat_d   = dat_q;
        case (state_q)
            ST_IDLE: begin
                if (access_fire) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    dat_d   = wb_we_i ? 32'h0 : rdata;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            ctrl_q     <= '0;
            prescale_q <= '0;
            pps_q      <= 1'b0;
            timer_q    <= '0;
            upd_q      <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pps_q      <= pps_d;
            timer_q    <= timer_d;
            upd_q      <= upd_d;
        end
    end

    for (genvar g = 0; g < NUM_SCALERS; g++) begin : g_ch
        scaler_channel #(
            .COUNT_WIDTH  (COUNT_WIDTH),
            .PRESCALE_BITS(PRESCALE_BITS)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .evt_i     (scal_i[g]),
            .strobe_i  (strobe),
            .clr_i     (psc_clr[g]),
            .prescale_i(prescale_q[g]),
            .count_o   (cnt_lat[g]),
            .sat_o     (sat_lat[g])
        );
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;

endmodule
